multicycle_chunk_adder: RTL and testbench
=========================================

Name: multicycle_chunk_adder

Overview:
- Parametrised successor of the fixed-width ripple adder.
- Adds two WIDTH-bit operands plus carry-in over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, LSB chunk first.
- A registered carry links successive chunks.
- Used where a full-width single-cycle carry chain would break timing. Trades latency for a short CHUNK-bit carry path.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be a multiple of CHUNK.
- CHUNK, 4: bits added per cycle, 1..WIDTH. NCH = WIDTH/CHUNK is the cycle count.

Ports:
- clk  input  1  : rising-edge clock.
- rst  input  1  : asynchronous reset, active-high.
- start  input  1  : request a new operation. Sampled only when the block is idle or in the done cycle.
- a  input  WIDTH  : operand A. Sampled with start.
- b  input  WIDTH  : operand B. Sampled with start.
- cin  input  1  : carry-in. Sampled with start.
- busy  output  1  : operation in progress.
- done  output  1  : one-cycle pulse; s and cout are valid from this cycle onward.
- s  output  WIDTH  : registered sum.
- cout  output  1  : registered carry-out.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, s=0, cout=0.
  - Internal operand, partial-sum and carry registers cleared; chunk counter=0.
  - Takes effect immediately, not at the next edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a, b, cin into internal registers; carry register = cin; counter = 0; go to RUN.
  - busy=1 from the cycle after the accepting edge.
- RUN:
  - Each edge adds chunk k = counter of the latched operands plus the carry register.
  - Writes the CHUNK-bit result into bits [k*CHUNK +: CHUNK] of the partial-sum register.
  - Carry register takes the chunk carry-out; counter increments.
  - start is ignored; latched operands are unchanged.
- RUN exit:
  - The edge processing chunk NCH-1 also copies the full partial sum to s and the final carry to cout.
  - Same edge sets done=1, busy=0, and goes to DONE.
- Latency: start sampled at edge E0; done high in the cycle after edge E(NCH).
  - Example: NCH=4 gives done 4 cycles after the start edge.
  - NCH=1 gives done the cycle after start.
- DONE:
  - Lasts exactly one cycle.
  - If start=1 on the exiting edge: accept new operands exactly as in IDLE and go to RUN (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Output holding:
  - s and cout change only on the completion edge or on reset.
  - They hold their value through IDLE and through the whole of the next RUN.
- Arithmetic:
  - {cout, s} = a + b + cin, exact modulo 2^(WIDTH+1).
  - Carry propagates across all chunk boundaries, e.g. 0xFFFF + 0 + 1.
- Reset during RUN: aborts the operation; no done pulse; outputs go to 0.
- No X propagation: all state registers are reset.

Optional Feature:
- Macro: MULTICYCLE_CHUNK_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1: latched B is replaced by ~b and the initial carry is forced to 1, so s = a - b mod 2^WIDTH. cin is ignored.
  - With sub=1, cout = 1 means no borrow (a >= b unsigned).
  - sub=0: plain addition as above.
  - Latency is identical for both modes.
- Not defined: sub port absent; addition only.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- Assert rst mid-cycle with no clock edge -> busy=0, done=0, s=0x0000, cout=0 immediately. Idle with start=0 for 10 cycles -> outputs unchanged.
- start with a=0x1234, b=0x4321, cin=0 -> busy=1 for 4 cycles; done pulse on the 4th cycle after the start edge; s=0x5555, cout=0. s holds 0x5555 afterwards.
- a=0xFFFF, b=0x0000, cin=1 -> s=0x0000, cout=1. Repeat with CHUNK=1 (16 cycles) and CHUNK=16 (1 cycle) -> same result, latency 16 and 1.
- Start a=0x00FF, b=0x0001; reassert start with a=0x1111, b=0x1111 during busy -> first result s=0x0100 only; no second done pulse.
- Reset asserted 2 cycles into RUN -> outputs go to 0 at once; no done pulse; a new start after reset completes normally.
- Back-to-back: start held high through the done cycle with a=0x8000, b=0x8000 -> second op accepted with no idle cycle; s=0x0000, cout=1.
- With SUB_EN: sub=1, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0.

Source files
------------

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle adder: {cout, s} = a + b + cin computed CHUNK bits per cycle, LSB chunk first.
// Optional subtract mode (input sub) is enabled by defining MULTICYCLE_CHUNK_ADDER_SUB_EN.
module multicycle_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MULTICYCLE_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [IW-1:0]    w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_chunk_sum;
  logic [WIDTH-1:0] w_psum_next;
  logic [WIDTH-1:0] w_b_sel;
  logic             w_carry_init;

  // Operand conditioning at accept time: subtract is a + ~b + 1.
  always_comb begin
    w_b_sel      = b;
    w_carry_init = cin;
`ifdef MULTICYCLE_CHUNK_ADDER_SUB_EN
    if (sub) begin
      w_b_sel      = ~b;
      w_carry_init = 1'b1;
    end else begin
      w_b_sel      = b;
      w_carry_init = cin;
    end
`endif
  end

  // One chunk of the addition; only this CHUNK-bit path is in the carry chain.
  always_comb begin
    w_base      = IW'(int'(r_cnt) * CHUNK);
    w_a_chunk   = r_a[w_base +: CHUNK];
    w_b_chunk   = r_b[w_base +: CHUNK];
    w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_psum_next = r_psum;
    w_psum_next[w_base +: CHUNK] = w_chunk_sum[CHUNK-1:0];
    w_last      = (r_cnt == CW'(NCH - 1));
  end

  // Next-state logic; start is only honoured when idle or in the done cycle.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand latch, per-chunk accumulation and result capture on the final chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_sel;
      r_carry <= w_carry_init;
      r_cnt   <= '0;
      r_psum  <= '0;
    end else if (r_state == S_RUN) begin
      r_psum  <= w_psum_next;
      r_carry <= w_chunk_sum[CHUNK];
      if (w_last) begin
        r_cnt  <= '0;
        r_s    <= w_psum_next;
        r_cout <= w_chunk_sum[CHUNK];
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_RUN);
      r_done <= (w_state_next == S_DONE);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Bench for multicycle_chunk_adder: three instances (CHUNK 4, 1, 16) share stimulus and are
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_multicycle_chunk_adder;
  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         cin;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   busy_v;
  logic [2:0]   done_v;
  logic [2:0]   cout_v;
  logic [W-1:0] s_v [3];

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_chunk_adder #(.WIDTH(W), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef MULTICYCLE_CHUNK_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0]));

  multicycle_chunk_adder #(.WIDTH(W), .CHUNK(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef MULTICYCLE_CHUNK_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1]));

  multicycle_chunk_adder #(.WIDTH(W), .CHUNK(16)) u2 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef MULTICYCLE_CHUNK_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int i);
    case (i)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic sb);
    logic [W-1:0] yn;
    yn = ~y;
    if (sb) return {1'b0, x} + {1'b0, yn} + 17'd1;
    else    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  // Transaction model: an accepted op completes lat_of(i) edges later with the exact sum.
  logic         m_busy [3];
  logic         m_done [3];
  logic         m_cout [3];
  logic [W-1:0] m_s    [3];
  logic [W:0]   m_res  [3];
  int           m_rem  [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_busy[i] <= 1'b0; m_done[i] <= 1'b0; m_cout[i] <= 1'b0;
        m_s[i] <= '0; m_res[i] <= '0; m_rem[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_busy[i]) begin
          if (m_rem[i] == 1) begin
            m_s[i] <= m_res[i][W-1:0]; m_cout[i] <= m_res[i][W];
            m_done[i] <= 1'b1; m_busy[i] <= 1'b0;
          end else begin
            m_rem[i] <= m_rem[i] - 1; m_done[i] <= 1'b0;
          end
        end else if (start) begin
          m_res[i] <= ref_sum(a, b, cin, sub);
          m_rem[i] <= lat_of(i); m_busy[i] <= 1'b1; m_done[i] <= 1'b0;
        end else begin
          m_done[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({busy_v[i], done_v[i], cout_v[i], s_v[i]} !== {m_busy[i], m_done[i], m_cout[i], m_s[i]}) begin
        n_bad++;
        $display("FAIL cycle inst%0d t=%0t: got busy=%b done=%b cout=%b s=%h, want busy=%b done=%b cout=%b s=%h",
                 i, $time, busy_v[i], done_v[i], cout_v[i], s_v[i], m_busy[i], m_done[i], m_cout[i], m_s[i]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                        input logic [W-1:0] es, input logic ec);
    int lat [3];
    @(negedge clk);
    start = 1'b1; a = aa; b = bb; cin = cc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (done_v[i] && lat[i] == 0) lat[i] = cyc;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("latency inst%0d", i), lat[i], lat_of(i));
      chk($sformatf("sum %h+%h inst%0d", aa, bb, i), {cout_v[i], s_v[i]}, {ec, es});
    end
  endtask

  initial begin
    int k;
    int ndone;
    rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset u0", {busy_v[0], done_v[0], cout_v[0], s_v[0]}, 32'd0);
    chk("reset u1", {busy_v[1], done_v[1], cout_v[1], s_v[1]}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle hold u0", {busy_v[0], done_v[0], cout_v[0], s_v[0]}, 32'd0);

    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    repeat (5) @(negedge clk);
    chk("hold 5555", s_v[0], 32'h5555);

    run_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);

    // start reasserted while busy must be ignored
    @(negedge clk); start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 16'h1111; b = 16'h1111;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("ignored start pulses", ndone, 1);
    chk("ignored start sum", {cout_v[0], s_v[0]}, 32'h00100);

    // asynchronous reset two cycles into RUN
    @(negedge clk); start = 1'b1; a = 16'h0003; b = 16'h0004;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("mid-run reset inst%0d", i), {busy_v[i], done_v[i], cout_v[i], s_v[i]}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0);

    // back-to-back with start held through the done cycle
    @(negedge clk); start = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0;
    k = 0;
    while (!done_v[0] && k < 20) begin @(negedge clk); k++; end
    chk("b2b first done", done_v[0], 1);
    chk("b2b first sum", {cout_v[0], s_v[0]}, 32'h10000);
    @(negedge clk);
    chk("b2b no bubble", {busy_v[0], done_v[0]}, 32'd2);
    start = 1'b0;
    k = 0;
    while (!done_v[0] && k < 20) begin @(negedge clk); k++; end
    chk("b2b second done", done_v[0], 1);
    chk("b2b second sum", {cout_v[0], s_v[0]}, 32'h10000);
    repeat (20) @(negedge clk);

`ifdef MULTICYCLE_CHUNK_ADDER_SUB_EN
    sub = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    run_op(16'h0009, 16'h0002, 1'b0, 16'h0007, 1'b1);
    sub = 1'b0;
`endif

    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a     = ($urandom_range(0, 5) == 0) ? 16'hFFFF : W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom_range(0, 1));
`ifdef MULTICYCLE_CHUNK_ADDER_SUB_EN
      sub   = 1'($urandom_range(0, 1));
`endif
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
